// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter: default widths, op codes
// presented to the shared bitwise unit, and FSM state encoding.
package logic_unit_arbiter_pkg;

  localparam int unsigned LU_WIDTH = 16;
  localparam int unsigned LU_CNT_W = 8;

  // Op codes understood by the shared logic unit
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // Transaction FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/logic_unit_arbiter_rr_arb2.sv
// Two-way round-robin grant.
// Ports:
//   req0_i, req1_i  : request valids
//   last_grant_i    : requester that won the previous grant
//   gnt0_c, gnt1_c  : combinational one-hot (or zero) grant
module logic_unit_arbiter_rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic gnt0_c,
  output logic gnt1_c
);

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    gnt0_c = req0_i & (~req1_i | last_grant_i);
    gnt1_c = req1_i & (~req0_i | ~last_grant_i);
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one external combinational 16-bit bitwise unit between two
// requesters. One transaction is in flight at a time: accept (IDLE),
// drive the unit for one cycle (EXEC), hold the result on the owner's
// response channel until consumed (RESP).
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b       : request channel of requester N
//   rspN_valid/ready/data         : response channel of requester N
//   lu_op/lu_a/lu_b, lu_out       : shared logic unit interface
//   busy                          : a transaction is in flight
//   done_cnt                      : wrapping count of completed transactions
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = LU_WIDTH,
  parameter int unsigned CNT_W = LU_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [1:0]       lu_op,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  input  logic [WIDTH-1:0] lu_out,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res0_q, res0_d;
  logic [WIDTH-1:0] res1_q, res1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0, gnt1;

  logic_unit_arbiter_rr_arb2 u_arb (
    .req0_i       (req0_valid),
    .req1_i       (req1_valid),
    .last_grant_i (last_grant_q),
    .gnt0_c       (gnt0),
    .gnt1_c       (gnt1)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state and request-ready logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    cnt_d        = cnt_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        // A grant implies the granted requester is valid, so grant == handshake.
        if (gnt0 | gnt1) begin
          owner_d      = gnt1;
          last_grant_d = gnt1;
          op_d         = gnt1 ? req1_op : req0_op;
          a_d          = gnt1 ? req1_a  : req0_a;
          b_d          = gnt1 ? req1_b  : req0_b;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (owner_q) res1_d = lu_out;
        else         res0_d = lu_out;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's ready completes the transaction.
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    lu_op      = (state_q == ST_EXEC) ? op_q : 2'b00;
    lu_a       = (state_q == ST_EXEC) ? a_q  : '0;
    lu_b       = (state_q == ST_EXEC) ? b_q  : '0;
    rsp0_valid = (state_q == ST_RESP) & ~owner_q;
    rsp1_valid = (state_q == ST_RESP) &  owner_q;
    rsp0_data  = res0_q;
    rsp1_data  = res1_q;
    busy       = (state_q != ST_IDLE);
    done_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
`timescale 1ns/1ps
module tb_logic_unit_arbiter;
  import logic_unit_arbiter_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]    req0_op, req1_op;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0]  rsp0_data, rsp1_data;
  logic [1:0]    lu_op;
  logic [W-1:0]  lu_a, lu_b, lu_out;
  logic          busy;
  logic [CW-1:0] done_cnt;

  logic          rand_rdy = 1'b0;
  logic          man_rdy0 = 1'b0, man_rdy1 = 1'b0;
  logic          rnd_rdy0 = 1'b0, rnd_rdy1 = 1'b0;
  assign rsp0_ready = rand_rdy ? rnd_rdy0 : man_rdy0;
  assign rsp1_ready = rand_rdy ? rnd_rdy1 : man_rdy1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  logic_unit_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .lu_op(lu_op), .lu_a(lu_a), .lu_b(lu_b), .lu_out(lu_out),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Reference meaning of each op code
  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Behavioural shared logic unit
  always_comb lu_out = ref_op(lu_op, lu_a, lu_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Random response-ready generator
  initial forever begin
    @(posedge clk); #1;
    rnd_rdy0 = ($urandom_range(0, 3) != 0);
    rnd_rdy1 = ($urandom_range(0, 3) != 0);
  end

  // Issue one request from requester n; expected result goes to the scoreboard.
  task automatic issue(input int n, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int budget;
    if (n == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
      exp_q0.push_back(ref_op(op, a, b));
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
      exp_q1.push_back(ref_op(op, a, b));
    end
    budget = 0;
    forever begin
      @(negedge clk);
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) break;
      budget++;
      if (budget > 400) begin
        checks++; errors++;
        $display("FAIL accept_timeout requester=%0d waited=%0d cycles limit=400", n, budget);
        break;
      end
    end
    @(posedge clk); #1;
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic rand_issue(input int n);
    issue(n, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 400) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", exp_q0.size() + exp_q1.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Transaction-level model: at most one job in flight, round-robin on ties,
  // response visible two edges after acceptance, scoreboard per requester.
  logic          inflight = 1'b0;
  logic          owner_m  = 1'b0;
  logic          last_g   = 1'b1;
  int            age      = 0;
  logic [CW-1:0] cnt_m    = '0;
  logic [1:0]    cap_op   = '0;
  logic [W-1:0]  cap_a    = '0, cap_b = '0;

  always @(negedge clk) begin
    logic g0, g1, ev0, ev1;
    if (reset) begin
      inflight = 1'b0; last_g = 1'b1; cnt_m = '0; age = 0;
      exp_q0.delete(); exp_q1.delete();
    end else begin
      chk("busy", 64'(busy), 64'(inflight));
      chk("done_cnt", 64'(done_cnt), 64'(cnt_m));
      ev0 = inflight && age >= 2 && !owner_m;
      ev1 = inflight && age >= 2 &&  owner_m;
      chk("rsp0_valid", 64'(rsp0_valid), 64'(ev0));
      chk("rsp1_valid", 64'(rsp1_valid), 64'(ev1));
      if (ev0) chk("rsp0_data_held", 64'(rsp0_data), 64'(ref_op(cap_op, cap_a, cap_b)));
      if (ev1) chk("rsp1_data_held", 64'(rsp1_data), 64'(ref_op(cap_op, cap_a, cap_b)));
      if (inflight && age == 1)
        chk("lu_drive", {30'd0, lu_op, lu_a, lu_b}, {30'd0, cap_op, cap_a, cap_b});
      else
        chk("lu_quiet", {30'd0, lu_op, lu_a, lu_b}, 64'd0);
      g0 = 1'b0; g1 = 1'b0;
      if (!inflight) begin
        if (req0_valid && req1_valid) begin
          g0 = last_g; g1 = !last_g;
        end else begin
          g0 = req0_valid; g1 = req1_valid;
        end
      end
      chk("req0_ready", 64'(req0_ready), 64'(g0));
      chk("req1_ready", 64'(req1_ready), 64'(g1));
      if (inflight) begin
        if (ev0 && rsp0_ready) begin
          if (exp_q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp0_unexpected data=%0h expected=none", rsp0_data);
          end else chk("rsp0_scoreboard", 64'(rsp0_data), 64'(exp_q0.pop_front()));
          cnt_m = cnt_m + CW'(1); inflight = 1'b0;
        end else if (ev1 && rsp1_ready) begin
          if (exp_q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp1_unexpected data=%0h expected=none", rsp1_data);
          end else chk("rsp1_scoreboard", 64'(rsp1_data), 64'(exp_q1.pop_front()));
          cnt_m = cnt_m + CW'(1); inflight = 1'b0;
        end else if (age < 2) begin
          age++;
        end
      end else if (g0 || g1) begin
        inflight = 1'b1; owner_m = g1; last_g = g1; age = 1;
        cap_op = g1 ? req1_op : req0_op;
        cap_a  = g1 ? req1_a  : req0_a;
        cap_b  = g1 ? req1_b  : req0_b;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    @(posedge clk); #1;

    // Single OR
    man_rdy0 = 1'b1; man_rdy1 = 1'b1;
    issue(0, OP_OR, 16'h00F0, 16'h0F0F);
    wait_drain();
    @(posedge clk); #1;
    chk("or_done_cnt", 64'(done_cnt), 64'd1);

    // Tie after reset: req0 first, then strict alternation
    do_reset();
    fork
      issue(0, OP_AND, 16'hFF00, 16'h0FF0);
      issue(1, OP_XOR, 16'hAAAA, 16'hFFFF);
    join
    repeat (3) begin
      fork
        rand_issue(0);
        rand_issue(1);
      join
    end
    wait_drain();
    @(posedge clk); #1;

    // Backpressure on requester 1 with requester 0 stalled and its ready high
    man_rdy1 = 1'b0; man_rdy0 = 1'b1;
    issue(1, OP_NOR, 16'h0000, 16'h00FF);
    fork
      issue(0, OP_OR, 16'h1234, 16'h0001);
    join_none
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_req0_stall", 64'(req0_ready), 64'd0);
    chk("bp_rsp1_valid", 64'(rsp1_valid), 64'd1);
    chk("bp_rsp1_data", 64'(rsp1_data), 64'h0000_FF00);
    @(posedge clk); #1;
    man_rdy1 = 1'b1;
    wait fork;
    wait_drain();
    @(posedge clk); #1;

    // Reset in the middle of an operation
    issue(0, OP_XOR, 16'h1357, 16'h2468);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_done_cnt", 64'(done_cnt), 64'd0);
    chk("mr_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    @(posedge clk); #1;
    fork
      issue(0, OP_AND, 16'hF0F0, 16'h3C3C);
      issue(1, OP_NOR, 16'h8001, 16'h0110);
    join
    wait_drain();

    // 256 random transactions from both sides wrap the counter
    do_reset();
    rand_rdy = 1'b1;
    fork
      repeat (128) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        rand_issue(0);
      end
      repeat (128) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        rand_issue(1);
      end
    join
    wait_drain();
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap_done_cnt", 64'(done_cnt), 64'd0);
    chk("wrap_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
